mem_access_unit: RTL

Load/store initiator between the CPU execute stage and the data port of the on-chip dual-port RAM. Accepts one load or store request at a time and generates word address, byte-lane write enables and lane-replicated store data. Aligns and sign/zero-extends returned load data and reports misaligned or illegal accesses as faults. Optional read-modify-write makes sub-word stores safe against responders that write the full word whenever any enable is set.

---
 rtl/mau_pkg.sv | 52 +++++
 rtl/mau_lane_align.sv | 31 +++
 rtl/mem_access_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mau_pkg.sv
// Shared encodings, FSM state type and lane helpers for the load/store initiator.
package mau_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        FLT  = 3'd4
    } state_t;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] m;
        case (size)
            SZ_BYTE: m = 4'b0001 << addr_lo;
            SZ_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [31:0] store_replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] r;
        case (size)
            SZ_BYTE: r = {4{data[7:0]}};
            SZ_HALF: r = {2{data[15:0]}};
            default: r = data;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] mask_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    function automatic logic bad_access(input logic [1:0] size, input logic [1:0] addr_lo);
        logic b;
        case (size)
            SZ_BYTE: b = 1'b0;
            SZ_HALF: b = addr_lo[0];
            SZ_WORD: b = (addr_lo != 2'b00);
            default: b = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Load lane extract/extend and read-modify-write merge, both fed from the captured RAM word.
module mau_lane_align
    import mau_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_data
);

    logic [31:0] shifted_s;
    logic [15:0] half_s;
    logic [31:0] lane_bits_s;

    // Extract the addressed lane and extend; word loads pass through untouched.
    always_comb begin
        shifted_s   = mem_word >> {addr_lo, 3'b000};
        half_s      = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
        lane_bits_s = mask_bits(lane_mask(size, addr_lo));
        case (size)
            SZ_BYTE: load_data = {{24{~is_unsigned & shifted_s[7]}}, shifted_s[7:0]};
            SZ_HALF: load_data = {{16{~is_unsigned & half_s[15]}}, half_s};
            default: load_data = mem_word;
        endcase
        merged_data = (mem_word & ~lane_bits_s) | (store_replicate(size, store_data) & lane_bits_s);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for the RAM data port: request latch, five-state FSM and registered outputs.
module mem_access_unit
    import mau_pkg::*;
#(
    parameter bit RMW_SUBWORD = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_web,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    state_t      state_r, next_state_s;
    logic        accept_s;
    logic        we_r, uns_r;
    logic [1:0]  size_r, addr_lo_r;
    logic [31:0] wdata_r;
    logic [31:0] load_data_s, merged_data_s;
    logic        resp_valid_nxt_s, resp_fault_nxt_s;
    logic [31:0] resp_rdata_nxt_s, mem_addr_nxt_s, mem_din_nxt_s;
    logic [3:0]  mem_web_nxt_s;

    assign req_ready = (state_r == IDLE);
    assign accept_s  = req_valid && (state_r == IDLE);

    mau_lane_align u_align (
        .size        (size_r),
        .is_unsigned (uns_r),
        .addr_lo     (addr_lo_r),
        .mem_word    (mem_dout),
        .store_data  (wdata_r),
        .load_data   (load_data_s),
        .merged_data (merged_data_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; sub-word stores take the read path only when merging.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (!accept_s) begin
                    next_state_s = IDLE;
                end else if (bad_access(req_size, req_addr[1:0])) begin
                    next_state_s = FLT;
                end else if (!req_we) begin
                    next_state_s = RD;
                end else if ((req_size == SZ_WORD) || !RMW_SUBWORD) begin
                    next_state_s = WR;
                end else begin
                    next_state_s = RD;
                end
            end
            RD:      next_state_s = CAP;
            CAP:     next_state_s = we_r ? WR : IDLE;
            WR:      next_state_s = IDLE;
            FLT:     next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; write enables only ever head into WR.
    always_comb begin
        resp_valid_nxt_s = 1'b0;
        resp_fault_nxt_s = 1'b0;
        resp_rdata_nxt_s = 32'h0000_0000;
        mem_addr_nxt_s   = mem_addr;
        mem_din_nxt_s    = mem_din;
        mem_web_nxt_s    = 4'b0000;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    mem_addr_nxt_s = {req_addr[31:2], 2'b00};
                    if (next_state_s == WR) begin
                        mem_web_nxt_s = lane_mask(req_size, req_addr[1:0]);
                        mem_din_nxt_s = store_replicate(req_size, req_wdata);
                    end else begin
                        mem_web_nxt_s = 4'b0000;
                    end
                end else begin
                    mem_web_nxt_s = 4'b0000;
                end
            end
            CAP: begin
                if (we_r) begin
                    mem_web_nxt_s = 4'b1111;
                    mem_din_nxt_s = merged_data_s;
                end else begin
                    resp_valid_nxt_s = 1'b1;
                    resp_rdata_nxt_s = load_data_s;
                end
            end
            WR: resp_valid_nxt_s = 1'b1;
            FLT: begin
                resp_valid_nxt_s = 1'b1;
                resp_fault_nxt_s = 1'b1;
            end
            default: resp_valid_nxt_s = 1'b0;
        endcase
    end

    // Request latch, loaded only on accept so later req_* changes are ignored.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we_r      <= 1'b0;
            uns_r     <= 1'b0;
            size_r    <= 2'b00;
            addr_lo_r <= 2'b00;
            wdata_r   <= 32'h0000_0000;
        end else if (accept_s) begin
            we_r      <= req_we;
            uns_r     <= req_unsigned;
            size_r    <= req_size;
            addr_lo_r <= req_addr[1:0];
            wdata_r   <= req_wdata;
        end else begin
            we_r      <= we_r;
            uns_r     <= uns_r;
            size_r    <= size_r;
            addr_lo_r <= addr_lo_r;
            wdata_r   <= wdata_r;
        end
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            mem_addr   <= 32'h0000_0000;
            mem_web    <= 4'b0000;
            mem_din    <= 32'h0000_0000;
        end else begin
            resp_valid <= resp_valid_nxt_s;
            resp_fault <= resp_fault_nxt_s;
            resp_rdata <= resp_rdata_nxt_s;
            mem_addr   <= mem_addr_nxt_s;
            mem_web    <= mem_web_nxt_s;
            mem_din    <= mem_din_nxt_s;
        end
    end

endmodule
